// File: rtl/pwm_trip_guard.sv
// Protection stage for a complementary PWM gate pair: registered pass-through with
// latched trips on filtered external fault or shoot-through, and a timed re-arm.
module pwm_trip_guard #(
  parameter int FILT_W   = 8,
  parameter int MINOFF_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_A,
  input  logic                pwm_B,
  input  logic                logic_A,
  input  logic                logic_B,
  input  logic                safe_A,
  input  logic                safe_B,
  input  logic                fault_in,
  input  logic [FILT_W-1:0]   filt_len,
  input  logic [MINOFF_W-1:0] min_off,
  input  logic                clear,
  output logic                pwmout_A,
  output logic                pwmout_B,
  output logic                trip,
  output logic [1:0]          trip_cause,
  output logic [7:0]          trip_count
);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    TRIPPED = 2'd1,
    REARM   = 2'd2
  } state_t;

  localparam logic [FILT_W-1:0]   FILT_ONE = FILT_W'(1);
  localparam logic [MINOFF_W-1:0] OFF_ONE  = MINOFF_W'(1);

  state_t              state_r;
  logic [1:0]          sync_r;
  logic                fault_s;
  logic [FILT_W-1:0]   filt_cnt_r;
  logic [FILT_W-1:0]   filt_lim_s;
  logic [FILT_W-1:0]   filt_nxt_s;
  logic                fault_ok_s;
  logic [MINOFF_W-1:0] off_cnt_r;
  logic [MINOFF_W-1:0] off_lim_s;
  logic                off_done_s;
  logic                shoot_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
  endfunction

  assign fault_s    = sync_r[1];
  assign filt_lim_s = (filt_len == '0) ? FILT_ONE : filt_len;
  assign off_lim_s  = (min_off == '0) ? OFF_ONE : min_off;
  assign off_done_s = (off_cnt_r >= off_lim_s);
  assign shoot_s    = (pwm_A == logic_A) && (pwm_B == logic_B);

  // Next filter count saturates at the limit; fault is confirmed when that next count hits it.
  always_comb begin
    filt_nxt_s = filt_cnt_r;
    if (filt_cnt_r >= filt_lim_s) begin
      filt_nxt_s = filt_lim_s;
    end else begin
      filt_nxt_s = filt_cnt_r + FILT_ONE;
    end
    fault_ok_s = fault_s && (filt_nxt_s == filt_lim_s);
  end

  // Fault synchronizer and consecutive-high filter counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r     <= 2'b00;
      filt_cnt_r <= '0;
    end else begin
      sync_r <= {sync_r[0], fault_in};
      if (!fault_s) begin
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_nxt_s;
      end
    end
  end

  // Trip FSM with registered outputs; the overlapping sample is never forwarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= REARM;
      off_cnt_r  <= '0;
      pwmout_A   <= 1'b0;
      pwmout_B   <= 1'b0;
      trip       <= 1'b0;
      trip_cause <= 2'b00;
      trip_count <= 8'd0;
    end else begin
      case (state_r)
        ARMED: begin
          if (fault_ok_s || shoot_s) begin
            state_r    <= TRIPPED;
            pwmout_A   <= safe_A;
            pwmout_B   <= safe_B;
            trip       <= 1'b1;
            trip_cause <= {shoot_s, fault_ok_s};
            trip_count <= sat_inc8(trip_count);
          end else begin
            pwmout_A <= pwm_A;
            pwmout_B <= pwm_B;
          end
        end
        TRIPPED: begin
          pwmout_A <= safe_A;
          pwmout_B <= safe_B;
          if (clear && !fault_s) begin
            state_r   <= REARM;
            off_cnt_r <= '0;
            trip      <= 1'b0;
          end else begin
            trip <= 1'b1;
          end
        end
        REARM: begin
          pwmout_A <= safe_A;
          pwmout_B <= safe_B;
          if (fault_ok_s) begin
            // Outputs are already safe here, so only the fault can be the cause.
            state_r    <= TRIPPED;
            trip       <= 1'b1;
            trip_cause <= 2'b01;
            trip_count <= sat_inc8(trip_count);
          end else if (off_done_s && !fault_s) begin
            state_r <= ARMED;
          end else if (!off_done_s) begin
            off_cnt_r <= off_cnt_r + OFF_ONE;
          end else begin
            off_cnt_r <= off_cnt_r;
          end
        end
        default: begin
          state_r   <= REARM;
          off_cnt_r <= '0;
          pwmout_A  <= safe_A;
          pwmout_B  <= safe_B;
          trip      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_trip_guard.sv
// Directed self-checking bench for pwm_trip_guard with hand-computed expectations.
module tb_pwm_trip_guard;

  logic       clk;
  logic       reset;
  logic       pwm_A, pwm_B, logic_A, logic_B, safe_A, safe_B;
  logic       fault_in, clear;
  logic [7:0] filt_len, min_off;
  logic       pwmout_A, pwmout_B, trip;
  logic [1:0] trip_cause;
  logic [7:0] trip_count;

  int n_vec = 0;
  int n_err = 0;

  pwm_trip_guard #(.FILT_W(8), .MINOFF_W(8)) dut (
    .clk(clk), .reset(reset),
    .pwm_A(pwm_A), .pwm_B(pwm_B),
    .logic_A(logic_A), .logic_B(logic_B),
    .safe_A(safe_A), .safe_B(safe_B),
    .fault_in(fault_in), .filt_len(filt_len), .min_off(min_off),
    .clear(clear),
    .pwmout_A(pwmout_A), .pwmout_B(pwmout_B),
    .trip(trip), .trip_cause(trip_cause), .trip_count(trip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    pwm_A = 1'b0; pwm_B = 1'b0;
    logic_A = 1'b1; logic_B = 1'b1;
    safe_A = 1'b0; safe_B = 1'b0;
    fault_in = 1'b0; clear = 1'b0;
    filt_len = 8'd3; min_off = 8'd4;

    // Reset values
    tick(); tick();
    check_eq("rst_outA", {31'd0, pwmout_A}, 32'd0);
    check_eq("rst_outB", {31'd0, pwmout_B}, 32'd0);
    check_eq("rst_trip", {31'd0, trip}, 32'd0);
    check_eq("rst_cause", {30'd0, trip_cause}, 32'd0);
    check_eq("rst_count", {24'd0, trip_count}, 32'd0);

    // 1: release after edge 0; safe through edge 5, forwarding from edge 6
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      pwm_A = k[0];
      pwm_B = ~k[0];
      tick();
      check_eq("rearm_outA", {31'd0, pwmout_A}, (k >= 6) ? {31'd0, k[0]} : 32'd0);
      check_eq("rearm_outB", {31'd0, pwmout_B}, (k >= 6) ? {31'd0, ~k[0]} : 32'd0);
      check_eq("rearm_trip", {31'd0, trip}, 32'd0);
    end

    // 2: shoot-through trips on the sampling edge
    pwm_A = 1'b1; pwm_B = 1'b1;
    tick();
    check_eq("shoot_outA", {31'd0, pwmout_A}, 32'd0);
    check_eq("shoot_outB", {31'd0, pwmout_B}, 32'd0);
    check_eq("shoot_trip", {31'd0, trip}, 32'd1);
    check_eq("shoot_cause", {30'd0, trip_cause}, 32'd2);
    check_eq("shoot_count", {24'd0, trip_count}, 32'd1);
    pwm_A = 1'b1; pwm_B = 1'b0;
    tick(); tick();
    check_eq("tripped_hold", {31'd0, trip}, 32'd1);
    check_eq("tripped_safeA", {31'd0, pwmout_A}, 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_trip", {31'd0, trip}, 32'd0);
    check_eq("clr_cause_kept", {30'd0, trip_cause}, 32'd2);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq("rearm4_outA", {31'd0, pwmout_A}, (k == 6) ? 32'd1 : 32'd0);
    end

    // 3: two-cycle fault pulse is filtered, held fault trips at edge 5
    fault_in = 1'b1;
    tick(); tick();
    fault_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("pulse_notrip", {31'd0, trip}, 32'd0);
    end
    fault_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq("filt_trip", {31'd0, trip}, (k == 5) ? 32'd1 : 32'd0);
      check_eq("filt_outA", {31'd0, pwmout_A}, (k == 5) ? 32'd0 : 32'd1);
    end
    check_eq("filt_cause", {30'd0, trip_cause}, 32'd1);
    check_eq("filt_count", {24'd0, trip_count}, 32'd2);

    // 4: clear during active fault is ignored and forgotten
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_ignored", {31'd0, trip}, 32'd1);
    tick();
    fault_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("clr_not_kept", {31'd0, trip}, 32'd1);
    end
    min_off = 8'd2;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr2_trip", {31'd0, trip}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("rearm2_outA", {31'd0, pwmout_A}, (k == 4) ? 32'd1 : 32'd0);
    end

    // 5: fault during REARM re-trips
    pwm_A = 1'b1; pwm_B = 1'b1;
    tick();
    check_eq("shoot2_count", {24'd0, trip_count}, 32'd3);
    pwm_A = 1'b1; pwm_B = 1'b0;
    min_off = 8'd20;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    filt_len = 8'd1;
    fault_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("rearm_fault_trip", {31'd0, trip}, (k == 3) ? 32'd1 : 32'd0);
    end
    check_eq("rearm_fault_cause", {30'd0, trip_cause}, 32'd1);
    check_eq("rearm_fault_count", {24'd0, trip_count}, 32'd4);

    // Fault and shoot-through on the same edge
    fault_in = 1'b0;
    tick(); tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    min_off = 8'd1;
    pwm_A = 1'b0; pwm_B = 1'b0;
    tick(); tick();
    fault_in = 1'b1;
    tick();
    check_eq("both_pre1", {31'd0, trip}, 32'd0);
    tick();
    check_eq("both_pre2", {31'd0, trip}, 32'd0);
    pwm_A = 1'b1; pwm_B = 1'b1;
    tick();
    check_eq("both_trip", {31'd0, trip}, 32'd1);
    check_eq("both_cause", {30'd0, trip_cause}, 32'd3);
    check_eq("both_count", {24'd0, trip_count}, 32'd5);

    // 300 more trips saturate the counter
    fault_in = 1'b0;
    pwm_A = 1'b0; pwm_B = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 300; i++) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick(); tick();
      pwm_A = 1'b1; pwm_B = 1'b1;
      tick();
      pwm_A = 1'b0; pwm_B = 1'b0;
      if (i == 9) check_eq("count_mid", {24'd0, trip_count}, 32'd15);
    end
    check_eq("count_sat", {24'd0, trip_count}, 32'd255);
    check_eq("sat_trip", {31'd0, trip}, 32'd1);
    check_eq("sat_cause", {30'd0, trip_cause}, 32'd2);

    // 6: asynchronous reset between edges while TRIPPED
    safe_A = 1'b1; safe_B = 1'b1;
    tick();
    check_eq("safe1_outA", {31'd0, pwmout_A}, 32'd1);
    check_eq("safe1_outB", {31'd0, pwmout_B}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_outA", {31'd0, pwmout_A}, 32'd0);
    check_eq("arst_outB", {31'd0, pwmout_B}, 32'd0);
    check_eq("arst_trip", {31'd0, trip}, 32'd0);
    check_eq("arst_cause", {30'd0, trip_cause}, 32'd0);
    check_eq("arst_count", {24'd0, trip_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_trip_guard.md
# pwm_trip_guard

Protection stage directly downstream of `pwm_16bits`. It consumes the complementary gate pair `pwmout_A`/`pwmout_B` and forwards it, registered, to the pins. It forces both outputs to configured safe levels on either of two trips:
- a filtered external fault;
- a shoot-through condition, with both legs at their active level in the same cycle.

The trip is latched and released only through an explicit clear followed by a minimum-off re-arm interval.

## Interface
- `FILT_W`, 8: width of the fault filter length and counter.
- `MINOFF_W`, 8: width of the re-arm interval counter.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `pwm_A`  in  1  leg A from the dead-time stage; synchronous to `clk`.
- `pwm_B`  in  1  leg B; synchronous to `clk`.
- `logic_A`  in  1  active level of leg A.
- `logic_B`  in  1  active level of leg B.
- `safe_A`  in  1  level driven on `pwmout_A` while not ARMED.
- `safe_B`  in  1  level driven on `pwmout_B` while not ARMED.
- `fault_in`  in  1  external fault, asynchronous, active-high.
- `filt_len`  in  FILT_W  consecutive synchronized-high cycles that confirm a fault; 0 is treated as 1.
- `min_off`  in  MINOFF_W  cycles the outputs stay safe in REARM; 0 is treated as 1.
- `clear`  in  1  single-cycle trip acknowledge.
- `pwmout_A`  out  1  protected leg A (registered).
- `pwmout_B`  out  1  protected leg B (registered).
- `trip`  out  1  high in TRIPPED.
- `trip_cause`  out  2  bit0 = fault, bit1 = shoot-through; captured at trip entry.
- `trip_count`  out  8  number of trips, saturating at 255.

## Operation
- `fault_in` passes through a 2-flop synchronizer to give `fault_s`.
- Filter counter:
  - increments while `fault_s`=1;
  - clears to 0 on any `fault_s`=0 sample;
  - saturates at `filt_len`.
- `fault_ok` is high when the counter would reach L = max(`filt_len`,1) on this edge.
- `shoot` = (`pwm_A`==`logic_A`) && (`pwm_B`==`logic_B`), evaluated on the current inputs.
- FSM states are ARMED, TRIPPED and REARM. The reset state is REARM with the off counter at 0.
- ARMED:
  - `pwmout_A`<=`pwm_A` and `pwmout_B`<=`pwm_B`.
  - If `fault_ok` or `shoot`, go to TRIPPED. On that same edge:
    - drive the outputs to the safe levels (the overlapping sample is never forwarded);
    - `trip_cause`<={`shoot`,`fault_ok`};
    - `trip_count`+1, saturating.
- TRIPPED:
  - Outputs are safe; `trip`=1.
  - `clear`=1 and `fault_s`=0: go to REARM with the off counter at 0.
  - `clear` while `fault_s`=1 is ignored and is not remembered.
- REARM:
  - Outputs are safe.
  - The off counter increments every cycle.
  - When the counter reaches max(`min_off`,1) and `fault_s`=0, go to ARMED. The first forwarded sample appears on the following edge.
  - `fault_ok` in REARM: go to TRIPPED with the same capture as from ARMED.
  - `shoot` is ignored in REARM because the outputs are already safe.
- Whenever the outputs are not forwarding, they are `safe_A`/`safe_B`, never the inputs.
- `trip_cause` holds its value until the next trip. It is not cleared by `clear`.
- Changes to `filt_len` or `min_off` take effect on the next counter comparison. No shadowing.

## Timing
- Reset values:
  - `pwmout_A`=0, `pwmout_B`=0;
  - `trip`=0, `trip_cause`=0, `trip_count`=0;
  - synchronizer and filter counter at 0;
  - state REARM.
- The first edge after reset release drives `safe_A`/`safe_B`.
- Pass-through latency in ARMED is 1 cycle.
- Shoot-through reaction: `trip` rises and the outputs go safe on the same edge that samples the overlap.
- Fault reaction: `fault_in` rises before edge 1 and stays high. `trip` rises and the outputs go safe at edge 2+L.
- A single low sample of `fault_s` restarts the filter.
- Re-arm timing: with `clear` sampled at edge c, ARMED is entered at edge c+1+max(`min_off`,1). The first forwarded output follows one edge later.
- Fault and shoot-through on the same edge give `trip_cause`=2'b11 and increment `trip_count` by exactly 1.
- `reset` asserted mid-operation immediately and asynchronously returns all state and outputs to the reset values.

## Test plan
1. **Reset and re-arm:**
   - Stimulus: `safe_A`=0, `safe_B`=0, `min_off`=4, inputs toggling; release reset at edge 0.
   - Required: outputs stay 0 through edge 5, follow the inputs with 1-cycle latency from edge 6, and `trip`=0.
2. **Shoot-through:**
   - Stimulus: `logic_A`=`logic_B`=1, `safe_A`=`safe_B`=0; in ARMED drive `pwm_A`=`pwm_B`=1 for one cycle.
   - Required: outputs are never 1/1; `trip`=1, `trip_cause`=2'b10, `trip_count`=1 on that edge.
3. **Fault filter:**
   - Stimulus: `filt_len`=3; pulse `fault_in` high for 2 cycles, then hold it high.
   - Required: the pulse causes no trip; for the hold, `trip` rises at edge 5 after the rising edge and `trip_cause`=2'b01.
4. **Clear while the fault is still active:**
   - Stimulus: `clear` while `fault_in`=1, then `clear` again after the fault drops, with `min_off`=2.
   - Required: the first clear is ignored; ARMED is entered 3 edges after the second clear.
5. **Fault in REARM and saturation:**
   - Stimulus: assert a fault during REARM; then force 300 trips.
   - Required: the fault in REARM returns the block to TRIPPED; after the 300 trips, `trip_count`=255.
6. **Asynchronous reset while TRIPPED:**
   - Stimulus: pulse `reset` between clock edges while TRIPPED.
   - Required: `trip`, `trip_cause`, `trip_count` and the outputs go to 0 immediately, without waiting for a clock edge.
